vx_fetch_credit_buf: RTL and testbench

Parametrised fetch-to-decode channel stage placed between the instruction fetch unit and the per-warp instruction buffers. It carries fetch packets over a valid/ready handshake and tracks per-warp instruction-buffer credits. A warp is accepted only while its downstream buffer has space; `ibuf_pop` pulses from the instruction buffer return credits. It adds an optional registered two-entry skid stage, a per-warp stall mask, an overflow error flag and an idle indication.

---
 rtl/vx_fetch_credit_buf.sv | 200 ++++++++++++++++++++
 tb/tb_vx_fetch_credit_buf.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_fetch_credit_buf.sv
// Fetch-to-decode channel stage with per-warp instruction-buffer credit tracking.
// Latency: OUT_REG=0 zero cycles (pass-through), OUT_REG=1 one cycle (two-entry skid).
// Backpressure: in_ready drops when the target warp has no credit or, with OUT_REG=1, the skid is full.
module vx_fetch_credit_buf #(
  parameter int NUM_WARPS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int IBUF_SIZE  = 4,
  parameter int OUT_REG    = 1,
  localparam int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int CRD_W     = $clog2(IBUF_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [WID_W-1:0]      in_wid,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [WID_W-1:0]      out_wid,
  input  logic                  out_ready,
  input  logic [NUM_WARPS-1:0]  ibuf_pop,
  output logic [NUM_WARPS-1:0]  warp_stall,
  output logic                  credit_err,
  output logic                  idle
);

  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(IBUF_SIZE);

  logic [CRD_W-1:0] credit_q [NUM_WARPS];
  logic [CRD_W-1:0] credit_d [NUM_WARPS];
  logic             err_q;
  logic             err_d;
  logic             has_credit;
  logic             accept;
  logic             all_full;
  logic             held_empty;

  // Credit lookup for the incoming warp; a loop keeps out-of-range wids credit-less.
  always_comb begin
    has_credit = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if ((in_wid == WID_W'(w)) && (credit_q[w] != '0)) begin
        has_credit = 1'b1;
      end
    end
  end

  assign accept = in_valid && in_ready;

  // Per-warp credit next state: pop returns one, accept consumes one, both net zero.
  always_comb begin
    err_d = err_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      credit_d[w] = credit_q[w];
      case ({ibuf_pop[w], accept && (in_wid == WID_W'(w))})
        2'b10: begin
          if (credit_q[w] == CRD_FULL) begin
            err_d = 1'b1;
          end else begin
            credit_d[w] = credit_q[w] + CRD_W'(1);
          end
        end
        2'b01: begin
          if (credit_q[w] != '0) begin
            credit_d[w] = credit_q[w] - CRD_W'(1);
          end
        end
        default: credit_d[w] = credit_q[w];
      endcase
    end
  end

  // Credit counters and sticky overflow flag; reset restores every warp to full.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        credit_q[w] <= CRD_FULL;
      end
      err_q <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        credit_q[w] <= credit_d[w];
      end
      err_q <= err_d;
    end
  end

  // Stall mask and idle come straight from the registered counters.
  always_comb begin
    all_full = 1'b1;
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_stall[w] = (credit_q[w] == '0);
      if (credit_q[w] != CRD_FULL) begin
        all_full = 1'b0;
      end
    end
  end

  assign credit_err = err_q;
  assign idle       = all_full && held_empty;

  if (OUT_REG == 0) begin : g_pass
    assign in_ready   = out_ready && has_credit;
    assign out_valid  = in_valid && has_credit;
    assign out_data   = in_data;
    assign out_wid    = in_wid;
    assign held_empty = 1'b1;
  end else begin : g_reg
    typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [DATA_WIDTH-1:0] head_dat_q;
    logic [WID_W-1:0]      head_wid_q;
    logic [DATA_WIDTH-1:0] skid_dat_q;
    logic [WID_W-1:0]      skid_wid_q;
    logic                  drain;
    logic                  load_head_in;
    logic                  load_head_skid;
    logic                  load_skid;

    // Ready is purely registered state plus in_wid: no path from out_ready.
    assign in_ready   = (state_q != S_TWO) && has_credit;
    assign out_valid  = (state_q != S_EMPTY);
    assign out_data   = head_dat_q;
    assign out_wid    = head_wid_q;
    assign held_empty = (state_q == S_EMPTY);
    assign drain      = out_valid && out_ready;

    // Occupancy state register.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= S_EMPTY;
      end else begin
        state_q <= state_d;
      end
    end

    // Next occupancy and which storage slot loads this cycle.
    always_comb begin
      state_d        = state_q;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d      = S_ONE;
            load_head_in = 1'b1;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            load_head_in = 1'b1;
          end else if (accept) begin
            state_d   = S_TWO;
            load_skid = 1'b1;
          end else if (drain) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (drain) begin
            state_d        = S_ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    // Head and skid storage; the head only changes on a load, so it holds while stalled.
    always_ff @(posedge clk) begin
      if (reset) begin
        head_dat_q <= '0;
        head_wid_q <= '0;
        skid_dat_q <= '0;
        skid_wid_q <= '0;
      end else begin
        if (load_head_in) begin
          head_dat_q <= in_data;
          head_wid_q <= in_wid;
        end else if (load_head_skid) begin
          head_dat_q <= skid_dat_q;
          head_wid_q <= skid_wid_q;
        end
        if (load_skid) begin
          skid_dat_q <= in_data;
          skid_wid_q <= in_wid;
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_fetch_credit_buf.sv
// Directed bench for vx_fetch_credit_buf (OUT_REG=1, 4 warps, 4 credits each).
// Expected packets are queued on accept and compared when decode takes them.
module tb_vx_fetch_credit_buf;

  localparam int NW = 4;
  localparam int DW = 64;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [WW-1:0] in_wid;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [WW-1:0] out_wid;
  logic          out_ready;
  logic [NW-1:0] ibuf_pop;
  logic [NW-1:0] warp_stall;
  logic          credit_err;
  logic          idle;

  typedef struct packed {
    logic [WW-1:0] wid;
    logic [DW-1:0] dat;
  } pkt_t;

  pkt_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  vx_fetch_credit_buf #(
    .NUM_WARPS (NW),
    .DATA_WIDTH(DW),
    .IBUF_SIZE (4),
    .OUT_REG   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_wid    (in_wid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_wid   (out_wid),
    .out_ready (out_ready),
    .ibuf_pop  (ibuf_pop),
    .warp_stall(warp_stall),
    .credit_err(credit_err),
    .idle      (idle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: record accepts, compare on every decode handshake (both stable at negedge).
  always @(negedge clk) begin
    pkt_t exp_p;
    if (reset) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back({in_wid, in_data});
      end
      if (out_valid && out_ready) begin
        vectors++;
        assert (sb.size() != 0) else begin
          miscompares++;
          $error("FAIL sb_underflow: observed output wid %0h data %0h expected none", out_wid, out_data);
        end
        if (sb.size() != 0) begin
          exp_p = sb.pop_front();
          chk("out_wid", 64'(out_wid), 64'(exp_p.wid));
          chk("out_data", out_data, exp_p.dat);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_wid    = '0;
    out_ready = 1'b1;
    ibuf_pop  = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_wid", 64'(out_wid), 64'd0);
    chk("rst_credit_err", 64'(credit_err), 64'd0);
    chk("rst_warp_stall", 64'(warp_stall), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Sequential fill of warp 1: exactly four accepts, one per cycle
    step();
    in_valid = 1'b1;
    in_wid   = 2'd1;
    for (int i = 0; i < 4; i++) begin
      in_data = 64'hA100_0000_0000_0000 + 64'(i);
      @(negedge clk);
      chk("fill_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) chk("fill_out_valid", 64'(out_valid), 64'd1);
      step();
    end
    in_data = 64'hA100_0000_0000_00FF;
    @(negedge clk);
    chk("fill5_in_ready", 64'(in_ready), 64'd0);
    chk("fill_warp_stall", 64'(warp_stall), 64'b0010);
    chk("fill_idle", 64'(idle), 64'd0);
    chk("fill_last_out_valid", 64'(out_valid), 64'd1);

    // Credit return: a pop does not enable acceptance in the same cycle
    step();
    ibuf_pop = 4'b0010;
    @(negedge clk);
    chk("pop_same_cycle_rdy", 64'(in_ready), 64'd0);
    step();
    ibuf_pop = '0;
    @(negedge clk);
    chk("pop_stall_clear", 64'(warp_stall), 64'd0);
    chk("pop_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pop_restall", 64'(warp_stall), 64'b0010);
    step();
    for (int i = 0; i < 4; i++) begin
      ibuf_pop = 4'b0010;
      step();
    end
    ibuf_pop = '0;
    @(negedge clk);
    chk("pop_idle", 64'(idle), 64'd1);
    chk("pop_no_err", 64'(credit_err), 64'd0);
    chk("pop_out_valid", 64'(out_valid), 64'd0);

    // Simultaneous accept and pop on warp 2 at credit 1
    step();
    in_valid = 1'b1;
    in_wid   = 2'd2;
    for (int i = 0; i < 3; i++) begin
      in_data = 64'hB200_0000_0000_0000 + 64'(i);
      step();
    end
    in_data  = 64'hB200_0000_0000_0010;
    ibuf_pop = 4'b0100;
    @(negedge clk);
    chk("simul_in_ready", 64'(in_ready), 64'd1);
    step();
    ibuf_pop = '0;
    in_data  = 64'hB200_0000_0000_0011;
    @(negedge clk);
    chk("simul_stall", 64'(warp_stall), 64'd0);
    chk("simul_in_ready2", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("simul_last_credit", 64'(warp_stall), 64'b0100);
    step();
    for (int i = 0; i < 4; i++) begin
      ibuf_pop = 4'b0100;
      step();
    end
    ibuf_pop = '0;
    @(negedge clk);
    chk("simul_idle", 64'(idle), 64'd1);
    chk("simul_no_err", 64'(credit_err), 64'd0);

    // Backpressure: two packets fill the skid, order and stability preserved
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_wid    = 2'd0;
    in_data   = 64'hAAAA_0000_0000_000A;
    @(negedge clk);
    chk("bp_a_rdy", 64'(in_ready), 64'd1);
    step();
    in_wid  = 2'd3;
    in_data = 64'hBBBB_0000_0000_000B;
    @(negedge clk);
    chk("bp_b_rdy", 64'(in_ready), 64'd1);
    step();
    in_wid  = 2'd0;
    in_data = 64'hCCCC_0000_0000_000C;
    @(negedge clk);
    chk("bp_full_rdy", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_head_data", out_data, 64'hAAAA_0000_0000_000A);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("bp_hold_data", out_data, 64'hAAAA_0000_0000_000A);
      chk("bp_hold_wid", 64'(out_wid), 64'd0);
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_a", out_data, 64'hAAAA_0000_0000_000A);
    step();
    @(negedge clk);
    chk("bp_second_b", out_data, 64'hBBBB_0000_0000_000B);
    chk("bp_second_wid", 64'(out_wid), 64'd3);
    step();
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);
    step();
    ibuf_pop = 4'b1001;
    step();
    ibuf_pop = '0;
    @(negedge clk);
    chk("bp_idle", 64'(idle), 64'd1);

    // Overflow: pop at full credits sets the sticky flag, counter holds
    step();
    ibuf_pop = 4'b0001;
    step();
    ibuf_pop = '0;
    @(negedge clk);
    chk("ovf_err", 64'(credit_err), 64'd1);
    chk("ovf_idle", 64'(idle), 64'd1);
    step();
    in_valid = 1'b1;
    in_wid   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      in_data = 64'hD000_0000_0000_0000 + 64'(i);
      @(negedge clk);
      chk("ovf_traffic_rdy", 64'(in_ready), 64'd1);
      step();
    end
    @(negedge clk);
    chk("ovf_exact_credits", 64'(in_ready), 64'd0);
    chk("ovf_stall", 64'(warp_stall), 64'b0001);
    chk("ovf_sticky", 64'(credit_err), 64'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ibuf_pop = 4'b0001;
      step();
    end
    ibuf_pop = '0;
    @(negedge clk);
    chk("ovf_restore_idle", 64'(idle), 64'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("ovf_reset_clear", 64'(credit_err), 64'd0);

    // Mid-operation reset with two packets held and credits 2/4/4/4
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_wid    = 2'd0;
    in_data   = 64'hE000_0000_0000_0001;
    step();
    in_data = 64'hE000_0000_0000_0002;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_held_valid", 64'(out_valid), 64'd1);
    chk("mid_idle_before", 64'(idle), 64'd0);
    step();
    reset    = 1'b1;
    ibuf_pop = 4'b0001;
    step();
    reset    = 1'b0;
    ibuf_pop = '0;
    @(negedge clk);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_idle", 64'(idle), 64'd1);
    chk("mid_stall", 64'(warp_stall), 64'd0);
    chk("mid_err", 64'(credit_err), 64'd0);
    chk("mid_out_data", out_data, 64'd0);

    // Traffic after reset flows normally
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_wid    = 2'd2;
    in_data   = 64'hF000_0000_0000_0002;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_out_valid", 64'(out_valid), 64'd1);
    chk("post_out_wid", 64'(out_wid), 64'd2);
    step();
    @(negedge clk);
    chk("post_sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
